// File: rtl/cla_addsub_pipe.sv
// ---------------------------------------------------------------------------
// cla_addsub_pipe
//   Pipelined carry-lookahead adder/subtractor built from a chain of 4-bit
//   lookahead groups, one register stage per group.  Stage k evaluates
//   group k using the carry handed over by stage k-1, so no carry ripples
//   across a register boundary.  Operand slices are skewed forward with the
//   carry, and lower sum nibbles ride along so the whole result leaves
//   together.  Valid/ready handshake with a single global advance signal.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high (clears all stage valid bits)
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle (= ~out_valid | out_ready)
//   A, B       operands, WIDTH bits
//   cin        carry-in, used only when sub=0
//   sub        0: A+B+cin, 1: A-B (A+~B+1)
//   out_valid  result beat present
//   out_ready  consumer accepts the result
//   S          sum/difference modulo 2^WIDTH
//   cout       carry out of MSB (not-borrow when sub=1)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//
// WIDTH must be a multiple of 4 and at least 4; pipeline depth is WIDTH/4.
// ---------------------------------------------------------------------------
module cla_addsub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);
    localparam int NG = WIDTH / 4;

    // 4-bit lookahead group. Returns {carry_out, carry_into_bit3, sum[3:0]}.
    function automatic logic [5:0] cla4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       c0
    );
        logic [3:0] p;
        logic [3:0] g;
        logic       c1, c2, c3, c4;
        p  = a ^ b;
        g  = a & b;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, c3, p ^ {c3, c2, c1, c0}};
    endfunction

    // Replace nibble k of a WIDTH-bit word.
    function automatic logic [WIDTH-1:0] put_nib(
        input logic [WIDTH-1:0] v,
        input logic [3:0]       n,
        input int               k
    );
        logic [WIDTH-1:0] r;
        r = v;
        r[4*k +: 4] = n;
        return r;
    endfunction

    // Stage k register holds the inputs of group k: skewed operands (only
    // slices k..NG-1 are still meaningful), the carry into group k, and the
    // already-finished sum nibbles 0..k-1.
    logic [NG-1:0]    vld_p;
    logic [WIDTH-1:0] a_p [NG];
    logic [WIDTH-1:0] b_p [NG];
    logic [WIDTH-1:0] s_p [NG];
    logic             c_p [NG];
    logic [5:0]       grp [NG];

    logic             adv;
    logic [WIDTH-1:0] b_mod;
    logic             c0;
    logic [5:0]       last;
    logic [WIDTH-1:0] s_full;

    assign b_mod     = sub ? ~B : B;
    assign c0        = sub | cin;
    assign out_valid = vld_p[NG-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;

    // Control: valid shift register, the only state under reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else if (adv) begin
            for (int k = NG - 1; k > 0; k--) begin
                vld_p[k] <= vld_p[k-1];
            end
            vld_p[0] <= in_valid;
        end
    end

    // Group evaluation for every stage, fed from that stage's register.
    always_comb begin
        for (int k = 0; k < NG; k++) begin
            grp[k] = cla4(a_p[k][4*k +: 4], b_p[k][4*k +: 4], c_p[k]);
        end
    end

    // Data path registers: loaded on advance, contents of invalid entries
    // are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (adv) begin
            // stage 0 boundary: capture operands, effective b and c0
            a_p[0] <= A;
            b_p[0] <= b_mod;
            c_p[0] <= c0;
            s_p[0] <= '0;
            // stage k-1 -> k boundary: hand over group k-1 carry and nibble
            for (int k = 1; k < NG; k++) begin
                a_p[k] <= a_p[k-1];
                b_p[k] <= b_p[k-1];
                c_p[k] <= grp[k-1][5];
                s_p[k] <= put_nib(s_p[k-1], grp[k-1][3:0], k - 1);
            end
        end
    end

    // Output: the last group completes the word. Outputs are forced to zero
    // whenever no result is present, which gives clean zeros after reset.
    assign last   = grp[NG-1];
    assign s_full = put_nib(s_p[NG-1], last[3:0], NG - 1);
    assign S      = out_valid ? s_full : '0;
    assign cout   = out_valid & last[5];
    assign ovf    = out_valid & (last[5] ^ last[4]);

endmodule

// File: tb/tb_cla_addsub_pipe.sv
module tb_cla_addsub_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv    [3];
    logic        ordy  [3];
    logic        cin_d [3];
    logic        sub_d [3];
    logic [31:0] a_d   [3];
    logic [31:0] b_d   [3];
    logic        ir    [3];
    logic        ov    [3];
    logic        co    [3];
    logic        of    [3];
    logic [3:0]  s4;
    logic [15:0] s16;
    logic [31:0] s32;
    logic [31:0] s_o   [3];

    assign s_o[0] = {28'd0, s4};
    assign s_o[1] = {16'd0, s16};
    assign s_o[2] = s32;

    int n_assert;
    int n_fail;

    logic [33:0] exp_q [3][$];

    cla_addsub_pipe #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .A(a_d[0][3:0]), .B(b_d[0][3:0]), .cin(cin_d[0]), .sub(sub_d[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .S(s4), .cout(co[0]), .ovf(of[0]));

    cla_addsub_pipe #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .A(a_d[1][15:0]), .B(b_d[1][15:0]), .cin(cin_d[1]), .sub(sub_d[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .S(s16), .cout(co[1]), .ovf(of[1]));

    cla_addsub_pipe #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .A(a_d[2]), .B(b_d[2]), .cin(cin_d[2]), .sub(sub_d[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .S(s32), .cout(co[2]), .ovf(of[2]));

    function automatic int wid(int i);
        case (i)
            0:       return 4;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [33:0] ref_op(int i, logic [31:0] a, logic [31:0] b,
                                           logic c, logic s);
        longint w, mask, half, ua, ub, sa, sb, full, sres;
        logic   rc, ro;
        w    = wid(i);
        mask = (longint'(1) <<< w) - 1;
        half = longint'(1) <<< (w - 1);
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        if (s) begin
            full = ua - ub;
            sres = sa - sb;
            rc   = (ua >= ub);
        end else begin
            full = ua + ub + longint'(c);
            sres = sa + sb + longint'(c);
            rc   = ((full >>> w) & 1) != 0;
        end
        ro = (sres > half - 1) || (sres < -half);
        return {rc, ro, 32'(full & mask)};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: account for handshakes offered in this cycle, then advance.
    task automatic tick();
        logic [33:0] e;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                exp_q[i].delete();
            end else begin
                chk($sformatf("in_ready_rule_w%0d", wid(i)), 64'(ir[i]),
                    64'(!ov[i] || ordy[i]));
                if (ov[i] && ordy[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("extra_beat_w%0d", wid(i)), 64'(ov[i]), 64'd0);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("S_w%0d", wid(i)), 64'(s_o[i]), 64'(e[31:0]));
                        chk($sformatf("cout_w%0d", wid(i)), 64'(co[i]), 64'(e[33]));
                        chk($sformatf("ovf_w%0d", wid(i)), 64'(of[i]), 64'(e[32]));
                    end
                end
                if (iv[i] && ir[i]) begin
                    exp_q[i].push_back(ref_op(i, a_d[i], b_d[i], cin_d[i], sub_d[i]));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops(int i);
        a_d[i]   = $urandom;
        b_d[i]   = $urandom;
        cin_d[i] = 1'($urandom_range(0, 1));
        sub_d[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic one_beat(int i, logic [31:0] a, logic [31:0] b, logic c, logic s,
                            logic [31:0] es, logic ec, logic eo, string tag);
        int edges;
        a_d[i] = a; b_d[i] = b; cin_d[i] = c; sub_d[i] = s; iv[i] = 1'b1;
        tick();
        iv[i] = 1'b0;
        edges = 1;
        while (!ov[i] && edges < 40) begin
            tick();
            edges++;
        end
        chk({tag, "_latency"}, 64'(edges), 64'(wid(i) / 4));
        chk({tag, "_S"}, 64'(s_o[i]), 64'(es));
        chk({tag, "_cout"}, 64'(co[i]), 64'(ec));
        chk({tag, "_ovf"}, 64'(of[i]), 64'(eo));
        tick();
    endtask

    task automatic stream(int i, int n);
        int          sent;
        int          cyc;
        int          cnt;
        logic        stall;
        logic        acc;
        logic [31:0] hs;
        logic        hc, ho;
        sent = 0;
        cyc  = 0;
        hs   = '0;
        hc   = 1'b0;
        ho   = 1'b0;
        rand_ops(i);
        iv[i] = 1'b1;
        while (sent < n && cyc < 200) begin
            stall   = (cyc >= 12 && cyc < 15);
            ordy[i] = !stall;
            #1;
            chk($sformatf("stall_in_ready_w%0d", wid(i)), 64'(ir[i]), 64'(!stall));
            if (cyc == 12) begin
                hs = s_o[i]; hc = co[i]; ho = of[i];
            end else if (stall) begin
                chk($sformatf("hold_S_w%0d", wid(i)), 64'(s_o[i]), 64'(hs));
                chk($sformatf("hold_cout_w%0d", wid(i)), 64'(co[i]), 64'(hc));
                chk($sformatf("hold_ovf_w%0d", wid(i)), 64'(of[i]), 64'(ho));
                chk($sformatf("hold_valid_w%0d", wid(i)), 64'(ov[i]), 64'd1);
            end
            acc = ir[i];
            tick();
            if (acc) begin
                sent++;
                rand_ops(i);
            end
            cyc++;
        end
        chk($sformatf("stream_sent_w%0d", wid(i)), 64'(sent), 64'(n));
        iv[i]   = 1'b0;
        ordy[i] = 1'b1;
        cnt = 0;
        while (exp_q[i].size() > 0 && cnt < 50) begin
            tick();
            cnt++;
        end
        chk($sformatf("stream_drained_w%0d", wid(i)), 64'(exp_q[i].size()), 64'd0);
        chk($sformatf("stream_idle_w%0d", wid(i)), 64'(ov[i]), 64'd0);
    endtask

    initial begin
        logic [33:0] r;
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; cin_d[i] = 1'b0; sub_d[i] = 1'b0;
            a_d[i] = '0; b_d[i] = '0;
        end
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_out_valid_w%0d", wid(i)), 64'(ov[i]), 64'd0);
            chk($sformatf("reset_in_ready_w%0d", wid(i)), 64'(ir[i]), 64'd1);
        end
        rst = 1'b0;

        repeat (10) begin
            tick();
            chk("idle_out_valid", 64'(ov[1]), 64'd0);
            chk("idle_S", 64'(s_o[1]), 64'd0);
            chk("idle_cout", 64'(co[1]), 64'd0);
            chk("idle_ovf", 64'(of[1]), 64'd0);
        end

        one_beat(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, "ripple");
        one_beat(1, 32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, "sub_ovf");
        one_beat(1, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0, "sub_neg");

        stream(1, 20);

        // Three beats in flight, then a reset with a beat offered alongside it.
        for (int k = 0; k < 3; k++) begin
            rand_ops(1);
            iv[1] = 1'b1;
            tick();
        end
        rand_ops(1);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        iv[1] = 1'b0;
        repeat (10) begin
            tick();
            chk("post_rst_no_out", 64'(ov[1]), 64'd0);
        end
        one_beat(1, 32'h0000_1234, 32'h0000_4321, 1'b1, 1'b0, 32'h5556, 1'b0, 1'b0, "after_rst");

        one_beat(0, 32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, "w4_cin");
        one_beat(2, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1,
                 "w32_cin_ovf");
        r = ref_op(2, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 1'b1);
        one_beat(2, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 1'b1, r[31:0], r[33], r[32], "w32_sub");

        stream(0, 20);
        stream(2, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
